// File: rtl/cloud_scroller.sv
// Three-cloud horizontal scroller: positions step left once per FRAME_DIV
// counted frame ticks, updating one cloud per clock in a short sequence.
module cloud_scroller #(
  parameter int SCREEN_W  = 640,
  parameter int CLOUD_W   = 50,
  parameter int FRAME_DIV = 2,
  parameter int INIT_X0   = 100,
  parameter int INIT_X1   = 320,
  parameter int INIT_X2   = 540,
  parameter int INIT_Y0   = 40,
  parameter int INIT_Y1   = 80,
  parameter int INIT_Y2   = 60,
  parameter int UPPER_MIN = 20,
  parameter int UPPER_MAX = 140
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       run,
  input  logic [2:0] speed,
  output logic [9:0] left0,
  output logic [9:0] upper0,
  output logic [9:0] left1,
  output logic [9:0] upper1,
  output logic [9:0] left2,
  output logic [9:0] upper2,
  output logic       busy,
  output logic       done,
  output logic [2:0] wrap
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UPD0 = 2'd1;
  localparam logic [1:0] UPD1 = 2'd2;
  localparam logic [1:0] UPD2 = 2'd3;

  localparam logic [9:0] SW     = 10'(SCREEN_W);
  localparam logic [9:0] LAST_X = 10'(SCREEN_W - 1);
  localparam logic [9:0] HID_X  = 10'(1024 - CLOUD_W);
  localparam logic [9:0] UMAX   = 10'(UPPER_MAX);
  localparam logic [9:0] SPAN   = 10'(UPPER_MAX - UPPER_MIN + 1);
  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  logic [1:0] state;
  logic [3:0] div;
  logic [2:0] spd;

  logic [9:0] cur_l;
  logic [9:0] cur_u;
  logic [9:0] nxt_l;
  logic [9:0] sum_u;
  logic [9:0] nxt_u;
  logic       hit;

  assign busy = (state != IDLE);

  always_comb begin
    cur_l = left0;
    cur_u = upper0;
    unique case (1'b1)
      (state == UPD1): begin
        cur_l = left1;
        cur_u = upper1;
      end
      (state == UPD2): begin
        cur_l = left2;
        cur_u = upper2;
      end
      default: begin
        cur_l = left0;
        cur_u = upper0;
      end
    endcase
    nxt_l = cur_l - {7'd0, spd};
    // Hidden band: fully off both edges, so the cloud re-enters on the right
    hit   = (nxt_l >= SW) && (nxt_l <= HID_X);
    sum_u = cur_u + 10'd23;
    nxt_u = (sum_u > UMAX) ? (sum_u - SPAN) : sum_u;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      div    <= '0;
      spd    <= '0;
      done   <= 1'b0;
      wrap   <= '0;
      left0  <= 10'(INIT_X0);
      left1  <= 10'(INIT_X1);
      left2  <= 10'(INIT_X2);
      upper0 <= 10'(INIT_Y0);
      upper1 <= 10'(INIT_Y1);
      upper2 <= 10'(INIT_Y2);
    end else begin
      done <= 1'b0;
      wrap <= '0;
      unique case (1'b1)
        (state == IDLE): begin
          if (frame_tick && run) begin
            if (div == DIV_LAST) begin
              div   <= '0;
              spd   <= speed;
              state <= UPD0;
            end else begin
              div <= div + 4'd1;
            end
          end
        end
        (state == UPD0): begin
          state   <= UPD1;
          left0   <= hit ? LAST_X : nxt_l;
          wrap[0] <= hit;
          if (hit) upper0 <= nxt_u;
        end
        (state == UPD1): begin
          state   <= UPD2;
          left1   <= hit ? LAST_X : nxt_l;
          wrap[1] <= hit;
          if (hit) upper1 <= nxt_u;
        end
        default: begin
          state   <= IDLE;
          done    <= 1'b1;
          left2   <= hit ? LAST_X : nxt_l;
          wrap[2] <= hit;
          if (hit) upper2 <= nxt_u;
        end
      endcase
    end
  end

endmodule
